// File: rtl/idu_pkg.sv
// rtl/idu_pkg.sv - shared constants and types for the IDU scheduler
package idu_pkg;

    localparam int IDU_W    = 16;
    localparam int REQ_PC   = 0;
    localparam int REQ_SP   = 1;
    localparam int REQ_MISC = 2;
    localparam int ID_BLK   = 3;

    typedef enum logic [2:0] {
        IDLE,
        HL,
        DE,
        BC,
        FIN
    } blk_state_t;

endpackage

// File: rtl/idu_prio_arb.sv
// rtl/idu_prio_arb.sv - fixed-priority one-hot grant, index 0 highest, with slot inhibit
module idu_prio_arb #(
    parameter int NREQ = 3
) (
    input  logic [NREQ-1:0] i_req,
    input  logic            i_inhibit,
    output logic [NREQ-1:0] o_gnt
);

    logic w_found;

    // Lowest-index pending request wins unless the slot is reserved.
    always_comb begin
        o_gnt   = '0;
        w_found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!i_inhibit && i_req[i] && !w_found) begin
                o_gnt[i] = 1'b1;
                w_found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/idu_sched.sv
// rtl/idu_sched.sv - IDU issue arbiter, block-transfer sequencer and result pipeline
module idu_sched
    import idu_pkg::*;
#(
    parameter int W    = IDU_W,
    parameter int NREQ = 3
) (
    input  logic              CLK,
    input  logic              nRESET,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] req_op,
    input  logic [NREQ-1:0]   req_dec,
    output logic [NREQ-1:0]   gnt,
    output logic [W-1:0]      res,
    output logic              res_cout,
    output logic              res_vld,
    output logic [1:0]        res_id,
    input  logic              blk_start,
    input  logic              blk_dec,
    input  logic [W-1:0]      blk_hl,
    input  logic [W-1:0]      blk_de,
    input  logic [W-1:0]      blk_bc,
    output logic [W-1:0]      blk_hl_o,
    output logic [W-1:0]      blk_de_o,
    output logic [W-1:0]      blk_bc_o,
    output logic              blk_bc_zero,
    output logic              blk_busy,
    output logic              blk_done,
    output logic [W-1:0]      idu_op,
    output logic              idu_en,
    output logic              idu_dec,
    input  logic [W-1:0]      idu_res,
    input  logic              idu_cout
);

    blk_state_t      r_state;
    logic [W-1:0]    r_hl;
    logic [W-1:0]    r_de;
    logic [W-1:0]    r_bc;
    logic            r_dir;
    logic [1:0]      r_iss_id;

    logic            w_blk_iss;
    logic [W-1:0]    w_blk_op;
    logic            w_blk_dec;
    logic            w_inhibit;
    logic [NREQ-1:0] w_gnt;
    logic [W-1:0]    w_sel_op;
    logic            w_sel_dec;
    logic [1:0]      w_sel_id;

    // Sequencer owns the IDU slot in HL, DE and BC; FIN leaves it free.
    always_comb begin
        w_blk_iss = 1'b1;
        w_blk_op  = r_hl;
        w_blk_dec = r_dir;
        case (r_state)
            HL: ;
            DE: w_blk_op = r_de;
            BC: begin
                w_blk_op  = r_bc;
                w_blk_dec = 1'b1;
            end
            default: w_blk_iss = 1'b0;
        endcase
    end

    assign w_inhibit = w_blk_iss || !nRESET;

    idu_prio_arb #(.NREQ(NREQ)) u_arb (
        .i_req     (req),
        .i_inhibit (w_inhibit),
        .o_gnt     (w_gnt)
    );

    assign gnt = w_gnt;

    // Mux the granted requester's operand, direction and index.
    always_comb begin
        w_sel_op  = '0;
        w_sel_dec = 1'b0;
        w_sel_id  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt[i]) begin
                w_sel_op  = req_op[i*W +: W];
                w_sel_dec = req_dec[i];
                w_sel_id  = 2'(i);
            end
        end
    end

    // Issue stage: load the IDU operand register; operand holds when idle.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            idu_op   <= '0;
            idu_en   <= 1'b0;
            idu_dec  <= 1'b0;
            r_iss_id <= '0;
        end else if (w_blk_iss) begin
            idu_op   <= w_blk_op;
            idu_en   <= 1'b1;
            idu_dec  <= w_blk_dec;
            r_iss_id <= 2'(ID_BLK);
        end else if (|w_gnt) begin
            idu_op   <= w_sel_op;
            idu_en   <= 1'b1;
            idu_dec  <= w_sel_dec;
            r_iss_id <= w_sel_id;
        end else begin
            idu_en   <= 1'b0;
        end
    end

    // Result stage: capture the IDU output one cycle after issue.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            res      <= '0;
            res_cout <= 1'b0;
            res_vld  <= 1'b0;
            res_id   <= '0;
        end else begin
            res_vld <= idu_en;
            if (idu_en) begin
                res      <= idu_res;
                res_cout <= idu_cout;
                res_id   <= r_iss_id;
            end
        end
    end

    // Block-transfer sequencer: each state captures the previous slot's result.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            r_state     <= IDLE;
            r_hl        <= '0;
            r_de        <= '0;
            r_bc        <= '0;
            r_dir       <= 1'b0;
            blk_hl_o    <= '0;
            blk_de_o    <= '0;
            blk_bc_o    <= '0;
            blk_bc_zero <= 1'b0;
            blk_busy    <= 1'b0;
            blk_done    <= 1'b0;
        end else begin
            blk_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (blk_start) begin
                        r_hl     <= blk_hl;
                        r_de     <= blk_de;
                        r_bc     <= blk_bc;
                        r_dir    <= blk_dec;
                        blk_busy <= 1'b1;
                        r_state  <= HL;
                    end
                end
                HL: r_state <= DE;
                DE: begin
                    blk_hl_o <= idu_res;
                    r_state  <= BC;
                end
                BC: begin
                    blk_de_o <= idu_res;
                    r_state  <= FIN;
                end
                FIN: begin
                    blk_bc_o    <= idu_res;
                    blk_bc_zero <= (idu_res == '0);
                    blk_done    <= 1'b1;
                    blk_busy    <= 1'b0;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_idu_sched.sv
// tb/tb_idu_sched.sv - randomized and directed self-checking bench for idu_sched
module tb_idu_sched;

    localparam int W = 16;

    logic          CLK = 1'b0;
    logic          nRESET;
    logic [2:0]    req;
    logic [47:0]   req_op;
    logic [2:0]    req_dec;
    logic [2:0]    gnt;
    logic [W-1:0]  res;
    logic          res_cout;
    logic          res_vld;
    logic [1:0]    res_id;
    logic          blk_start;
    logic          blk_dec;
    logic [W-1:0]  blk_hl, blk_de, blk_bc;
    logic [W-1:0]  blk_hl_o, blk_de_o, blk_bc_o;
    logic          blk_bc_zero, blk_busy, blk_done;
    logic [W-1:0]  idu_op;
    logic          idu_en, idu_dec;
    logic [W-1:0]  idu_res;
    logic          idu_cout;

    logic [W-1:0]  t_op [3];

    int checks = 0;
    int failures = 0;

    // reference arithmetic: {carry/borrow, result}
    function automatic logic [16:0] f_idu(input logic [15:0] v, input logic d);
        if (d) return {1'b0, v} - 17'd1;
        else   return {1'b0, v} + 17'd1;
    endfunction

    always #5 CLK = ~CLK;

    assign req_op = {t_op[2], t_op[1], t_op[0]};
    assign {idu_cout, idu_res} = idu_en ? f_idu(idu_op, idu_dec) : {1'b0, idu_op};

    idu_sched dut (
        .CLK(CLK), .nRESET(nRESET), .req(req), .req_op(req_op), .req_dec(req_dec),
        .gnt(gnt), .res(res), .res_cout(res_cout), .res_vld(res_vld), .res_id(res_id),
        .blk_start(blk_start), .blk_dec(blk_dec), .blk_hl(blk_hl), .blk_de(blk_de),
        .blk_bc(blk_bc), .blk_hl_o(blk_hl_o), .blk_de_o(blk_de_o), .blk_bc_o(blk_bc_o),
        .blk_bc_zero(blk_bc_zero), .blk_busy(blk_busy), .blk_done(blk_done),
        .idu_op(idu_op), .idu_en(idu_en), .idu_dec(idu_dec),
        .idu_res(idu_res), .idu_cout(idu_cout)
    );

    // model: m_seq counts sequence slots after blk_start (0 = idle, 1..3 issue, 4 = final capture)
    int            m_seq;
    logic          m_iss_vld, m_out_vld, m_done;
    logic [15:0]   m_iss_val, m_out_val;
    logic          m_iss_c, m_out_c;
    logic [1:0]    m_iss_id, m_out_id;
    logic [15:0]   m_hl, m_de, m_bc;
    logic          m_dir;
    logic [15:0]   e_hl, e_de, e_bc;
    logic          e_z;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_seq = 0; m_iss_vld = 0; m_out_vld = 0; m_done = 0;
        e_hl = 0; e_de = 0; e_bc = 0; e_z = 0;
    endtask

    task automatic cyc();
        logic [2:0]  eg;
        logic [16:0] r;
        int          idx;
        @(negedge CLK);
        eg = 3'b000;
        if (!(m_seq >= 1 && m_seq <= 3)) begin
            if (req[0])      eg = 3'b001;
            else if (req[1]) eg = 3'b010;
            else if (req[2]) eg = 3'b100;
        end
        chk("gnt", gnt, eg);
        chk("res_vld", res_vld, m_out_vld);
        if (m_out_vld) begin
            chk("res", res, m_out_val);
            chk("res_cout", res_cout, m_out_c);
            chk("res_id", res_id, m_out_id);
        end
        chk("blk_done", blk_done, m_done);
        chk("blk_busy", blk_busy, m_seq != 0);
        chk("blk_hl_o", blk_hl_o, e_hl);
        chk("blk_de_o", blk_de_o, e_de);
        chk("blk_bc_o", blk_bc_o, e_bc);
        chk("blk_bc_zero", blk_bc_zero, e_z);
        @(posedge CLK);
        m_out_vld = m_iss_vld; m_out_val = m_iss_val; m_out_c = m_iss_c; m_out_id = m_iss_id;
        m_done = (m_seq == 4);
        if (m_seq == 2) begin r = f_idu(m_hl, m_dir); e_hl = r[15:0]; end
        if (m_seq == 3) begin r = f_idu(m_de, m_dir); e_de = r[15:0]; end
        if (m_seq == 4) begin r = f_idu(m_bc, 1'b1); e_bc = r[15:0]; e_z = (r[15:0] == 16'h0); end
        m_iss_vld = 1'b1;
        if (m_seq == 1)      begin r = f_idu(m_hl, m_dir); m_iss_id = 2'd3; end
        else if (m_seq == 2) begin r = f_idu(m_de, m_dir); m_iss_id = 2'd3; end
        else if (m_seq == 3) begin r = f_idu(m_bc, 1'b1);  m_iss_id = 2'd3; end
        else if (eg != 0) begin
            idx = eg[0] ? 0 : (eg[1] ? 1 : 2);
            r = f_idu(t_op[idx], req_dec[idx]);
            m_iss_id = 2'(idx);
        end else begin
            m_iss_vld = 1'b0;
        end
        m_iss_val = r[15:0];
        m_iss_c   = r[16];
        if (m_seq == 0) begin
            if (blk_start) begin
                m_hl = blk_hl; m_de = blk_de; m_bc = blk_bc; m_dir = blk_dec;
                m_seq = 1;
            end
        end else if (m_seq == 4) begin
            m_seq = 0;
        end else begin
            m_seq++;
        end
        #1;
        req = req & ~eg;
        blk_start = 1'b0;
    endtask

    task automatic do_reset();
        nRESET = 1'b0;
        model_reset();
        @(negedge CLK);
        chk("rst_gnt", gnt, 0);
        chk("rst_res", res, 0);
        chk("rst_res_cout", res_cout, 0);
        chk("rst_res_vld", res_vld, 0);
        chk("rst_res_id", res_id, 0);
        chk("rst_blk_hl_o", blk_hl_o, 0);
        chk("rst_blk_de_o", blk_de_o, 0);
        chk("rst_blk_bc_o", blk_bc_o, 0);
        chk("rst_blk_bc_zero", blk_bc_zero, 0);
        chk("rst_blk_busy", blk_busy, 0);
        chk("rst_blk_done", blk_done, 0);
        chk("rst_idu_op", idu_op, 0);
        chk("rst_idu_en", idu_en, 0);
        chk("rst_idu_dec", idu_dec, 0);
        @(posedge CLK);
        #1 nRESET = 1'b1;
    endtask

    function automatic logic [15:0] rnd_op();
        case ($urandom_range(0, 3))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        nRESET = 1'b0; req = 0; req_dec = 0; blk_start = 0; blk_dec = 0;
        blk_hl = 0; blk_de = 0; blk_bc = 0;
        t_op[0] = 0; t_op[1] = 0; t_op[2] = 0;
        #2;
        do_reset();

        // single PC increment
        t_op[0] = 16'h1234; req_dec = 3'b000; req = 3'b001;
        repeat (3) cyc();

        // three requesters at once: priority order on consecutive slots
        t_op[0] = 16'h0000; t_op[1] = 16'hFFFF; t_op[2] = 16'h8000;
        req_dec = 3'b010; req = 3'b111;
        repeat (5) cyc();

        // wrap both ways on the SP port
        t_op[1] = 16'hFFFF; req_dec[1] = 1'b0; req = 3'b010; cyc();
        t_op[1] = 16'h0000; req_dec[1] = 1'b1; req = 3'b010;
        repeat (3) cyc();

        // block sequence with req[0] held and a second blk_start while busy
        blk_hl = 16'h4000; blk_de = 16'h5000; blk_bc = 16'h0001; blk_dec = 1'b0;
        blk_start = 1'b1; cyc();
        t_op[0] = 16'h00AA; req_dec[0] = 1'b0; req = 3'b001; cyc();
        blk_hl = 16'h1111; blk_start = 1'b1; cyc();
        repeat (5) cyc();

        // blk_start and req[1] together in IDLE: request takes that slot
        t_op[1] = 16'h0010; req_dec[1] = 1'b1; req = 3'b010;
        blk_hl = 16'h0000; blk_de = 16'hFFFF; blk_bc = 16'h0005; blk_dec = 1'b1;
        blk_start = 1'b1;
        repeat (7) cyc();

        // reset the cycle after a grant
        t_op[2] = 16'h0F0F; req_dec[2] = 1'b0; req = 3'b100; cyc();
        do_reset();
        repeat (3) cyc();

        // reset during the DE slot
        blk_hl = 16'h2000; blk_de = 16'h3000; blk_bc = 16'h0002; blk_dec = 1'b0;
        blk_start = 1'b1; cyc(); cyc();
        do_reset();
        repeat (3) cyc();

        // randomized traffic
        repeat (400) begin
            for (int i = 0; i < 3; i++) begin
                if (!req[i] && ($urandom_range(0, 2) == 0)) begin
                    t_op[i] = rnd_op();
                    req_dec[i] = 1'($urandom_range(0, 1));
                    req[i] = 1'b1;
                end
            end
            if ($urandom_range(0, 7) == 0) begin
                blk_hl = rnd_op(); blk_de = rnd_op();
                blk_bc = ($urandom_range(0, 1) == 0) ? 16'h0001 : rnd_op();
                blk_dec = 1'($urandom_range(0, 1));
                blk_start = 1'b1;
            end
            cyc();
        end
        req = 0;
        repeat (6) cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
